ml555_config_sequencer: RTL
===========================

Name: ml555_config_sequencer

Overview:
Clocked configuration sequencer for the ML555 board CPLD. It sits directly upstream of the CPLD's PROG_B, FLASH_CF_B and flash chip-enable routing and produces those signals, replacing the pass-through of the raw pushbutton.
- Debounces the PROG pushbutton.
- Issues a timed PROG_B pulse.
- Supervises INIT_B and DONE with timeouts.
- On failure, retries from the alternate Platform Flash image a bounded number of times.

Parameters:
DEB_CYCLES, 50000, cycles the synchronized PROG_SW_B must stay low before a press is accepted (~1.5 ms at 33 MHz)
PROG_PULSE_CYCLES, 33, PROG_B low time in cycles (1 µs at 33 MHz; must be at least the FPGA's tPROGRAM)
INIT_TIMEOUT_CYCLES, 33000, maximum wait for INIT_B to go high after PROG_B releases
DONE_TIMEOUT_CYCLES, 16500000, maximum wait for FPGA_DONE after INIT_B goes high (~500 ms)
MAX_RETRIES, 1, fallback attempts before declaring failure (0..3)

Ports:
CLK  in  1  free-running CPLD oscillator; the only clock
RST_B  in  1  reset, asynchronous assert, active-low
PROG_SW_B  in  1  raw pushbutton, active-low, asynchronous, bouncing
IMAGE_SEL_REQ  in  1  strap (P3 image1 select): primary image, 0=PF0, 1=PF1
INIT_B  in  1  FPGA INIT_B, asynchronous
FPGA_DONE  in  1  FPGA DONE, asynchronous
PROG_B  out  1  to FPGA PROG_B, active-low
FLASH_CF_B  out  1  to Platform Flash CF_B; always equal to PROG_B
IMAGE_SEL  out  1  image in use; drives the downstream CE_B/CE1_B mux
CFG_FAIL  out  1  sticky failure flag
RETRY_CNT  out  2  retries consumed in the current sequence
CFG_STATE  out  3  current state code (debug/LED)

Behaviour:
Reset and output timing
- All outputs are registered.
- While RST_B is low: PROG_B=1, FLASH_CF_B=1, IMAGE_SEL=0, CFG_FAIL=0, RETRY_CNT=0, CFG_STATE=IDLE, all counters 0.

Input conditioning
- PROG_SW_B, INIT_B and FPGA_DONE each pass through a 2-flop synchronizer; the FSM sees only synchronized values.
- Debounce: a counter runs while the synchronized button is low and clears when it is high.
- When the counter reaches DEB_CYCLES, emit one single-cycle press event.
- No further event until the button has been seen high for at least 1 cycle.

Sequence start (shared by every entry to PROG from IDLE, CONFIGURED or FAIL, and by any press restart)
- Latch IMAGE_SEL from IMAGE_SEL_REQ.
- Clear RETRY_CNT and CFG_FAIL.
- Clear the pulse/timeout counter.

State encoding
- IDLE=0, PROG=1, WAIT_INIT=2, WAIT_DONE=3, CONFIGURED=4, RETRY=5, FAIL=6.

Transitions
- IDLE: the first cycle after reset release performs a sequence start and enters PROG (power-on sequence).
- PROG: PROG_B is low for exactly PROG_PULSE_CYCLES cycles, then goes to WAIT_INIT with the counter cleared.
- WAIT_INIT:
  - INIT_B high → WAIT_DONE, counter cleared.
  - Counter reaches INIT_TIMEOUT_CYCLES → RETRY.
- WAIT_DONE:
  - DONE high → CONFIGURED.
  - INIT_B low (CRC error) → RETRY.
  - Counter reaches DONE_TIMEOUT_CYCLES → RETRY.
  - DONE and INIT_B low in the same cycle: DONE wins.
- RETRY (one cycle):
  - RETRY_CNT < MAX_RETRIES: RETRY_CNT += 1, IMAGE_SEL inverted, → PROG.
  - Otherwise → FAIL with CFG_FAIL=1.
- CONFIGURED: DONE low → IDLE. No automatic reprogram; CFG_STATE reads 0.
- FAIL: hold. PROG_B=1. CFG_FAIL stays set.

Press handling
- A press in any state performs a sequence start and enters PROG.
- This includes mid-sequence: the current attempt is abandoned and the counter reset.
- A press has priority over every other transition in the same cycle.

Strap
- IMAGE_SEL_REQ changes are ignored except at a sequence start.

Counter sizing
- One shared pulse/timeout counter, wide enough for the largest of PROG_PULSE_CYCLES, INIT_TIMEOUT_CYCLES and DONE_TIMEOUT_CYCLES (24 bits at defaults).
- The counter saturates and never wraps.
- The debounce counter is sized for DEB_CYCLES.

Latency
- Press: PROG_B falls 1 cycle after the press event.
- Press event = 2 sync cycles + DEB_CYCLES after the raw button goes low.

Decomposition:
- Shared package ml555_cfg_pkg holds:
  - state encodings and CFG_STATE codes;
  - default cycle constants;
  - a ceiling-log2 function for counter widths.
- One sub-module: ml555_debounce, containing the synchronizer, debounce counter and single-cycle press output, parameterised by DEB_CYCLES.
- The input synchronizers for INIT_B and FPGA_DONE are inline.

Test Plan:
Bench parameters: DEB_CYCLES=4, PROG_PULSE_CYCLES=8, INIT_TIMEOUT_CYCLES=64, DONE_TIMEOUT_CYCLES=256, MAX_RETRIES=1.
1. Release reset with IMAGE_SEL_REQ=1; raise INIT_B 3 cycles after PROG_B rises and DONE 20 cycles later → PROG_B low exactly 8 cycles, IMAGE_SEL=1, CFG_STATE 1→2→3→4, CFG_FAIL=0.
2. Bounce PROG_SW_B low/high every 2 cycles for 20 cycles, then hold low 10 cycles → no PROG_B pulse during bounce; exactly one 8-cycle pulse starting 7 cycles after the stable-low edge.
3. Keep INIT_B low after the pulse → RETRY at counter 64, IMAGE_SEL toggles 0→1, RETRY_CNT=1, second 8-cycle pulse; INIT_B still low → FAIL, CFG_FAIL=1, PROG_B held 1.
4. In WAIT_DONE, drop INIT_B low (CRC error) → RETRY next cycle, IMAGE_SEL inverted; then complete normally → CONFIGURED with RETRY_CNT=1.
5. In WAIT_DONE, assert the press event and DONE in the same cycle → PROG entered, RETRY_CNT=0, IMAGE_SEL reloaded from IMAGE_SEL_REQ; also toggle IMAGE_SEL_REQ mid-sequence → IMAGE_SEL unchanged.
6. Assert RST_B low during PROG → PROG_B=1 asynchronously, all outputs at reset values; on release a fresh 8-cycle pulse is issued.

Source files
------------

// File: rtl/ml555_cfg_pkg.sv
// ml555_cfg_pkg
//   Shared definitions for the ML555 CPLD configuration sequencer:
//   - CFG_STATE codes (also the FSM state encoding)
//   - default cycle constants for a 33 MHz CPLD oscillator
//   - ceil_log2() for sizing counters from cycle constants
package ml555_cfg_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PROG       = 3'd1;
  localparam logic [2:0] ST_WAIT_INIT  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_CONFIGURED = 3'd4;
  localparam logic [2:0] ST_RETRY      = 3'd5;
  localparam logic [2:0] ST_FAIL       = 3'd6;

  localparam int DEF_DEB_CYCLES          = 50000;
  localparam int DEF_PROG_PULSE_CYCLES   = 33;
  localparam int DEF_INIT_TIMEOUT_CYCLES = 33000;
  localparam int DEF_DONE_TIMEOUT_CYCLES = 16500000;
  localparam int DEF_MAX_RETRIES         = 1;

  // ceil(log2(value)); a counter that must hold N needs ceil_log2(N + 1) bits.
  function automatic int ceil_log2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ml555_debounce.sv
// ml555_debounce
//   Synchronizes and debounces the active-low PROG pushbutton.
//   Ports:
//     clk    in   CPLD clock
//     rst_b  in   asynchronous active-low reset
//     btn_b  in   raw pushbutton, active-low, asynchronous
//     press  out  registered single-cycle press event
//   A press is accepted once the synchronized button has been low for
//   DEB_CYCLES consecutive cycles; the counter then parks at DEB_CYCLES so
//   no further event fires until the button has been seen high.
module ml555_debounce
  import ml555_cfg_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_b,
  input  logic btn_b,
  output logic press
);

  localparam int CNT_BITS = ceil_log2(DEB_CYCLES + 1);
  localparam int CNT_W    = (CNT_BITS < 1) ? 1 : CNT_BITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEB_CYCLES);

  logic             btn_sync_p0;
  logic             btn_sync_p1;
  logic [CNT_W-1:0] deb_cnt;

  // Two-flop synchronizer; idles released (high).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      btn_sync_p0 <= 1'b1;
      btn_sync_p1 <= 1'b1;
    end else begin
      btn_sync_p0 <= btn_b;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // Debounce counter and press event
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      deb_cnt <= '0;
      press   <= 1'b0;
    end else if (btn_sync_p1) begin
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      press <= (deb_cnt == CNT_LAST);
      if (deb_cnt != CNT_SAT) deb_cnt <= deb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ml555_config_sequencer.sv
// ml555_config_sequencer
//   Clocked FPGA configuration sequencer for the ML555 CPLD. Debounces the
//   PROG pushbutton, issues a timed PROG_B pulse, supervises INIT_B / DONE
//   with timeouts and falls back to the alternate Platform Flash image a
//   bounded number of times.
//   Ports:
//     CLK            in   CPLD oscillator, only clock
//     RST_B          in   asynchronous active-low reset
//     PROG_SW_B      in   raw PROG pushbutton, active-low
//     IMAGE_SEL_REQ  in   primary image strap (0=PF0, 1=PF1)
//     INIT_B         in   FPGA INIT_B (asynchronous)
//     FPGA_DONE      in   FPGA DONE (asynchronous)
//     PROG_B         out  FPGA PROG_B, active-low
//     FLASH_CF_B     out  Platform Flash CF_B, same as PROG_B
//     IMAGE_SEL      out  image in use (drives CE_B/CE1_B mux)
//     CFG_FAIL       out  sticky failure flag
//     RETRY_CNT      out  retries consumed in this sequence
//     CFG_STATE      out  current state code
module ml555_config_sequencer
  import ml555_cfg_pkg::*;
#(
  parameter int DEB_CYCLES          = DEF_DEB_CYCLES,
  parameter int PROG_PULSE_CYCLES   = DEF_PROG_PULSE_CYCLES,
  parameter int INIT_TIMEOUT_CYCLES = DEF_INIT_TIMEOUT_CYCLES,
  parameter int DONE_TIMEOUT_CYCLES = DEF_DONE_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       CLK,
  input  logic       RST_B,
  input  logic       PROG_SW_B,
  input  logic       IMAGE_SEL_REQ,
  input  logic       INIT_B,
  input  logic       FPGA_DONE,
  output logic       PROG_B,
  output logic       FLASH_CF_B,
  output logic       IMAGE_SEL,
  output logic       CFG_FAIL,
  output logic [1:0] RETRY_CNT,
  output logic [2:0] CFG_STATE
);

  localparam int MAX_PI  = (PROG_PULSE_CYCLES > INIT_TIMEOUT_CYCLES) ?
                           PROG_PULSE_CYCLES : INIT_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_PI > DONE_TIMEOUT_CYCLES) ? MAX_PI : DONE_TIMEOUT_CYCLES;
  localparam int TMR_W   = ceil_log2(MAX_CYC + 1);

  // Terminal values are one less than the cycle counts because the timer
  // reads 0 on the first cycle spent in a state.
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PROG_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] DONE_LAST  = TMR_W'(DONE_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRIES);

  logic             init_sync_p0, init_sync_p1;
  logic             done_sync_p0, done_sync_p1;
  logic             press;
  logic [2:0]       state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             timed;
  logic             do_start, do_retry, do_fail;
  logic             por_pend;
  logic             prog_b_q, image_sel_q, cfg_fail_q;
  logic [1:0]       retry_q;

  ml555_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (CLK),
    .rst_b (RST_B),
    .btn_b (PROG_SW_B),
    .press (press)
  );

  // INIT_B / DONE synchronizers
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      init_sync_p0 <= 1'b0;
      init_sync_p1 <= 1'b0;
      done_sync_p0 <= 1'b0;
      done_sync_p1 <= 1'b0;
    end else begin
      init_sync_p0 <= INIT_B;
      init_sync_p1 <= init_sync_p0;
      done_sync_p0 <= FPGA_DONE;
      done_sync_p1 <= done_sync_p0;
    end
  end

  // Next-state logic; a press overrides everything else.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_retry  = 1'b0;
    do_fail   = 1'b0;
    if (press) begin
      state_nxt = ST_PROG;
      do_start  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (por_pend) begin
            state_nxt = ST_PROG;
            do_start  = 1'b1;
          end
        end
        ST_PROG: begin
          if (tmr == PULSE_LAST) state_nxt = ST_WAIT_INIT;
        end
        ST_WAIT_INIT: begin
          if (init_sync_p1)           state_nxt = ST_WAIT_DONE;
          else if (tmr == INIT_LAST)  state_nxt = ST_RETRY;
        end
        ST_WAIT_DONE: begin
          // DONE is checked first so it wins over a simultaneous INIT_B drop.
          if (done_sync_p1)           state_nxt = ST_CONFIGURED;
          else if (!init_sync_p1)     state_nxt = ST_RETRY;
          else if (tmr == DONE_LAST)  state_nxt = ST_RETRY;
        end
        ST_RETRY: begin
          if (retry_q < RETRY_MAX) begin
            state_nxt = ST_PROG;
            do_retry  = 1'b1;
          end else begin
            state_nxt = ST_FAIL;
            do_fail   = 1'b1;
          end
        end
        ST_CONFIGURED: begin
          if (!done_sync_p1) state_nxt = ST_IDLE;
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign timed = (state == ST_PROG) || (state == ST_WAIT_INIT) || (state == ST_WAIT_DONE);

  // Shared pulse/timeout timer: cleared on every state entry and restart,
  // saturating so a stuck state can never wrap into a false terminal count.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      tmr <= '0;
    end else if (do_start || (state_nxt != state) || !timed) begin
      tmr <= '0;
    end else if (tmr != '1) begin
      tmr <= tmr + 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state       <= ST_IDLE;
      prog_b_q    <= 1'b1;
      image_sel_q <= 1'b0;
      cfg_fail_q  <= 1'b0;
      retry_q     <= 2'd0;
      por_pend    <= 1'b1;
    end else begin
      state    <= state_nxt;
      // PROG_B is low exactly while the registered state is PROG.
      prog_b_q <= (state_nxt != ST_PROG);
      if (do_start) begin
        image_sel_q <= IMAGE_SEL_REQ;
        retry_q     <= 2'd0;
        cfg_fail_q  <= 1'b0;
        por_pend    <= 1'b0;
      end else if (do_retry) begin
        retry_q     <= retry_q + 2'd1;
        image_sel_q <= ~image_sel_q;
      end else if (do_fail) begin
        cfg_fail_q  <= 1'b1;
      end
    end
  end

  assign PROG_B     = prog_b_q;
  assign FLASH_CF_B = prog_b_q;
  assign IMAGE_SEL  = image_sel_q;
  assign CFG_FAIL   = cfg_fail_q;
  assign RETRY_CNT  = retry_q;
  assign CFG_STATE  = state;

endmodule
